// File: rtl/alu_32.sv
// -----------------------------------------------------------------------------
// alu_32
// MIPS-style execute-stage ALU. Decodes a 4-bit ALU control code into
// AND / OR / ADD / SUB / SLT / NOR on two operands and registers the result.
// Zero is a purely combinational operand-equality flag for branch resolution.
//
// Ports:
//   clk        in   1      system clock, Result updates on rising edge
//   rst_n      in   1      asynchronous active-low reset, clears Result
//   DataIn1    in   WIDTH  operand A
//   DataIn2    in   WIDTH  operand B
//   Operation  in   4      ALU control code
//   Result     out  WIDTH  registered operation result (1-cycle latency)
//   Zero       out  1      combinational, 1 when DataIn1 == DataIn2
// -----------------------------------------------------------------------------
module alu_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] DataIn1,
    input  logic [WIDTH-1:0] DataIn2,
    input  logic [3:0]       Operation,
    output logic [WIDTH-1:0] Result,
    output logic             Zero
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    // A native signed compare stays correct when A - B overflows,
    // unlike taking the sign bit of the difference.
    function automatic logic [WIDTH-1:0] slt_fn(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic lt;
        lt = (a < b);
        return {{(WIDTH-1){1'b0}}, lt};
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [WIDTH-1:0] alu_p0;
    logic        [WIDTH-1:0] result_p1;

    assign a_s = DataIn1;
    assign b_s = DataIn2;

    // ---- stage p0: combinational decode ----
    always_comb begin
        alu_p0 = '0;
        case (Operation)
            OP_AND:  alu_p0 = DataIn1 & DataIn2;
            OP_OR:   alu_p0 = DataIn1 | DataIn2;
            OP_ADD:  alu_p0 = DataIn1 + DataIn2;
            OP_SUB:  alu_p0 = DataIn1 - DataIn2;
            OP_SLT:  alu_p0 = slt_fn(a_s, b_s);
            OP_NOR:  alu_p0 = ~(DataIn1 | DataIn2);
            // Unused and unknown codes resolve to zero so nothing latches.
            default: alu_p0 = '0;
        endcase
    end

    // ---- stage p1: registered result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= '0;
        end else begin
            result_p1 <= alu_p0;
        end
    end

    assign Result = result_p1;

    // Equality flag bypasses the register so branches resolve in-cycle.
    assign Zero = (DataIn1 == DataIn2);

endmodule

// File: tb/tb_alu_32.sv
module tb_alu_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] DataIn1;
    logic [31:0] DataIn2;
    logic [3:0]  Operation;
    logic [31:0] Result;
    logic        Zero;

    int tests_run;
    int tests_failed;

    alu_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .DataIn1   (DataIn1),
        .DataIn2   (DataIn2),
        .Operation (Operation),
        .Result    (Result),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Operation = op;
        DataIn1   = a;
        DataIn2   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        DataIn1 = 32'd1;
        DataIn2 = 32'd1;
        Operation = 4'd2;
        #1;
        tests_run++;
        if (Result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_initial: got %h want 00000000", Result);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (Result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_held: got %h want 00000000", Result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (Result !== 32'h2) begin
            tests_failed++;
            $display("FAIL pre_reset_add: got %h want 00000002", Result);
        end
        // Assert reset mid-cycle with Result nonzero; must clear without an edge.
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (Result !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h want 00000000", Result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd2, 32'd1, 32'd1);
        tests_run++;
        if (Result !== 32'h2) begin
            tests_failed++;
            $display("FAIL post_reset_add: got %h want 00000002", Result);
        end
    endtask

    task automatic test_ops();
        logic [3:0]  ops [6];
        logic [31:0] exp [6];
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        exp = '{32'h00011400, 32'hD29D7FA5, 32'hD29E93A5,
                32'h518BD6A3, 32'h00000000, 32'h2D62805A};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], 32'h12153524, 32'hC0895E81);
            tests_run++;
            if (Result !== exp[i]) begin
                tests_failed++;
                $display("FAIL op_%0d: got %h want %h", ops[i], Result, exp[i]);
            end
            tests_run++;
            if (Zero !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_op_%0d: got %b want 0", ops[i], Zero);
            end
        end
    endtask

    task automatic test_unused_ops();
        logic [3:0] ops [10];
        ops = '{4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
        // Load a nonzero value first so a stuck register would be visible.
        drive(4'd1, 32'h12153524, 32'hC0895E81);
        for (int i = 0; i < 10; i++) begin
            drive(ops[i], 32'h12153524, 32'hC0895E81);
            tests_run++;
            if (Result !== 32'h0) begin
                tests_failed++;
                $display("FAIL unused_op_%0d: got %h want 00000000", ops[i], Result);
            end
        end
    endtask

    task automatic test_slt();
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] exp [4];
        a   = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000005};
        b   = '{32'h00000001, 32'h80000000, 32'h7FFFFFFF, 32'h00000005};
        exp = '{32'h1, 32'h0, 32'h1, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(4'd7, a[i], b[i]);
            tests_run++;
            if (Result !== exp[i]) begin
                tests_failed++;
                $display("FAIL slt_%h_%h: got %h want %h", a[i], b[i], Result, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        drive(4'd2, 32'hFFFFFFFF, 32'h00000001);
        tests_run++;
        if (Result !== 32'h00000000) begin
            tests_failed++;
            $display("FAIL add_wrap: got %h want 00000000", Result);
        end
        drive(4'd6, 32'h00000000, 32'h00000001);
        tests_run++;
        if (Result !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL sub_wrap: got %h want FFFFFFFF", Result);
        end
    endtask

    task automatic test_zero();
        drive(4'd1, 32'h12153524, 32'hC0895E81);
        // Mid-cycle, no clock edge between change and sample.
        #2;
        DataIn1 = 32'hC0895E81;
        DataIn2 = 32'hC0895E81;
        Operation = 4'd6;
        #1;
        tests_run++;
        if (Zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_equal: got %b want 1", Zero);
        end
        tests_run++;
        if (Result !== 32'hD29D7FA5) begin
            tests_failed++;
            $display("FAIL result_held_midcycle: got %h want D29D7FA5", Result);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (Result !== 32'h0) begin
            tests_failed++;
            $display("FAIL sub_equal: got %h want 00000000", Result);
        end
        DataIn2 = 32'hC0895E80;
        #1;
        tests_run++;
        if (Zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_clear: got %b want 0", Zero);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_ops();
        test_unused_ops();
        test_slt();
        test_wrap();
        test_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
